cache_snoop_ctrl: RTL and testbench

Parametrised upstream-snoop handler for the L2-side MESI cache; the successor to the fixed single-path SUREQ flow. It owns a direct-mapped tag/state/data array of NUM_SETS lines and accepts snoops (RD/RFO/INV) from the upstream bus. When the line is MIGRATED, it recalls the line from L1 through the CUREQ/CDRSP channel before answering on SDRSP. It adds a bounded-wait timeout on the L1 recall and a local fill port for installing lines.

---
 rtl/cache_snoop_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_cache_snoop_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_snoop_ctrl.sv
// L2-side snoop handler: answers upstream RD/RFO/INV snoops from a direct-mapped MESI array,
// recalling MIGRATED lines from L1 under a bounded wait, with a local fill port for installs.
module cache_snoop_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int NUM_SETS = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sureq_valid,
  output logic              sureq_ready,
  input  logic [1:0]        sureq_op,
  input  logic [ADDR_W-1:0] sureq_addr,
  output logic              sdrsp_valid,
  input  logic              sdrsp_ready,
  output logic [1:0]        sdrsp_rsp,
  output logic [DATA_W-1:0] sdrsp_data,
  output logic              cureq_valid,
  input  logic              cureq_ready,
  output logic [1:0]        cureq_op,
  output logic [ADDR_W-1:0] cureq_addr,
  input  logic              cdrsp_valid,
  output logic              cdrsp_ready,
  input  logic [1:0]        cdrsp_rsp,
  input  logic [DATA_W-1:0] cdrsp_data,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [2:0]        fill_state,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy
);
  // state       | meaning
  // IDLE        | accept a snoop, or a fill when no snoop is offered
  // ALLOCATE    | look up the indexed line, decide hit / recall
  // INIT_CUREQ  | offer the recall to L1 until accepted
  // WAIT_CDRSP  | wait for the L1 recall data, bounded by TIMEOUT
  // UPDATE      | form the response and apply the line state change
  // SEND_RSP    | hold the response until the upstream accepts it

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [2:0] LS_INVALID  = 3'b000;
  localparam logic [2:0] LS_SHARED   = 3'b101;
  localparam logic [2:0] LS_MIGRATED = 3'b111;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_RFO = 2'b01;
  localparam logic [1:0] OP_BAD = 2'b11;

  localparam logic [1:0] RSP_OKAY  = 2'b00;
  localparam logic [1:0] RSP_INV   = 2'b01;
  localparam logic [1:0] RSP_ERROR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE       = 3'b000,
    S_ALLOCATE   = 3'b001,
    S_INIT_CUREQ = 3'b010,
    S_WAIT_CDRSP = 3'b011,
    S_UPDATE     = 3'b110,
    S_SEND_RSP   = 3'b111
  } fsm_t;

  logic [TAG_W-1:0]  tag_mem  [NUM_SETS];
  logic [2:0]        st_mem   [NUM_SETS];
  logic [DATA_W-1:0] data_mem [NUM_SETS];

  fsm_t              state;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic              hit_q;
  logic              err_q;
  logic [DATA_W-1:0] line_q;
  logic [1:0]        rsp_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [CNT_W-1:0]  cnt;

  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  fill_idx;
  logic              line_hit;
  logic              fill_fire;
  logic              line_wr;

  assign idx_q     = addr_q[IDX_W-1:0];
  assign tag_q     = addr_q[ADDR_W-1:IDX_W];
  assign fill_idx  = fill_addr[IDX_W-1:0];
  assign line_hit  = st_mem[idx_q][0] && (tag_mem[idx_q] == tag_q);
  assign fill_fire = fill_valid && fill_ready;
  // Keep the (possibly recalled) line data once the snoop has been answered from it.
  assign line_wr   = !rst && (state == S_UPDATE) && hit_q && !err_q;

  always_ff @(posedge clk) begin
    if (fill_fire) begin
      tag_mem[fill_idx]  <= fill_addr[ADDR_W-1:IDX_W];
      data_mem[fill_idx] <= fill_data;
    end else if (line_wr) begin
      data_mem[idx_q] <= line_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      hit_q      <= 1'b0;
      err_q      <= 1'b0;
      line_q     <= '0;
      rsp_q      <= '0;
      rsp_data_q <= '0;
      cnt        <= '0;
      for (int i = 0; i < NUM_SETS; i++) st_mem[i] <= LS_INVALID;
    end else begin
      case (state)
        S_IDLE: begin
          if (sureq_valid) begin
            op_q   <= sureq_op;
            addr_q <= sureq_addr;
            state  <= S_ALLOCATE;
          end else if (fill_valid) begin
            st_mem[fill_idx] <= fill_state;
          end
        end
        S_ALLOCATE: begin
          hit_q  <= line_hit;
          line_q <= data_mem[idx_q];
          err_q  <= (op_q == OP_BAD);
          if (op_q != OP_BAD && line_hit && st_mem[idx_q] == LS_MIGRATED) state <= S_INIT_CUREQ;
          else                                                            state <= S_UPDATE;
        end
        S_INIT_CUREQ: begin
          if (cureq_ready) begin
            cnt   <= '0;
            state <= S_WAIT_CDRSP;
          end
        end
        S_WAIT_CDRSP: begin
          cnt <= cnt + 1'b1;
          if (cdrsp_valid) begin
            if (cdrsp_rsp == 2'b00) line_q <= cdrsp_data;
            else                    err_q  <= 1'b1;
            state <= S_UPDATE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          state <= S_SEND_RSP;
          if (err_q) begin
            rsp_q      <= RSP_ERROR;
            rsp_data_q <= '0;
          end else if (!hit_q) begin
            rsp_q      <= RSP_OKAY;
            rsp_data_q <= '0;
          end else begin
            case (op_q)
              OP_RD: begin
                rsp_q         <= RSP_OKAY;
                rsp_data_q    <= line_q;
                st_mem[idx_q] <= LS_SHARED;
              end
              OP_RFO: begin
                rsp_q         <= RSP_INV;
                rsp_data_q    <= line_q;
                st_mem[idx_q] <= LS_INVALID;
              end
              default: begin
                rsp_q         <= RSP_INV;
                rsp_data_q    <= '0;
                st_mem[idx_q] <= LS_INVALID;
              end
            endcase
          end
        end
        S_SEND_RSP: begin
          if (sdrsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Every output is forced low while rst is asserted, whatever state the FSM was in.
  assign sureq_ready = !rst && (state == S_IDLE);
  assign fill_ready  = !rst && (state == S_IDLE) && !sureq_valid;
  assign busy        = !rst && (state != S_IDLE);
  assign cureq_valid = !rst && (state == S_INIT_CUREQ);
  assign cureq_op    = cureq_valid ? op_q : '0;
  assign cureq_addr  = cureq_valid ? addr_q : '0;
  assign cdrsp_ready = !rst && (state == S_WAIT_CDRSP);
  assign sdrsp_valid = !rst && (state == S_SEND_RSP);
  assign sdrsp_rsp   = sdrsp_valid ? rsp_q : '0;
  assign sdrsp_data  = sdrsp_valid ? rsp_data_q : '0;

endmodule

// File: tb/tb_cache_snoop_ctrl.sv
// Bench for cache_snoop_ctrl: directed plan plus random snoop/fill traffic, checked every cycle
// against a transaction-level MESI model of the line array.
`timescale 1ns/1ps
module tb_cache_snoop_ctrl;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 32;
  localparam int NUM_SETS = 16;
  localparam int TIMEOUT  = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sureq_valid = 1'b0;
  logic              sureq_ready;
  logic [1:0]        sureq_op = '0;
  logic [ADDR_W-1:0] sureq_addr = '0;
  logic              sdrsp_valid;
  logic              sdrsp_ready = 1'b0;
  logic [1:0]        sdrsp_rsp;
  logic [DATA_W-1:0] sdrsp_data;
  logic              cureq_valid;
  logic              cureq_ready = 1'b0;
  logic [1:0]        cureq_op;
  logic [ADDR_W-1:0] cureq_addr;
  logic              cdrsp_valid = 1'b0;
  logic              cdrsp_ready;
  logic [1:0]        cdrsp_rsp = '0;
  logic [DATA_W-1:0] cdrsp_data = '0;
  logic              fill_valid = 1'b0;
  logic              fill_ready;
  logic [ADDR_W-1:0] fill_addr = '0;
  logic [2:0]        fill_state = '0;
  logic [DATA_W-1:0] fill_data = '0;
  logic              busy;

  int errors = 0;
  int checks = 0;

  // Model of the line array and of the transaction currently in flight
  logic [2:0]        m_st  [NUM_SETS];
  logic [11:0]       m_tag [NUM_SETS];
  logic [DATA_W-1:0] m_dat [NUM_SETS];
  bit                in_txn = 1'b0;
  bit                exp_recall = 1'b0;
  logic [1:0]        exp_rsp = '0;
  logic [DATA_W-1:0] exp_data = '0;
  logic [1:0]        exp_cop = '0;
  logic [ADDR_W-1:0] exp_caddr = '0;
  logic [2:0]        fill_sts [6] = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b111, 3'b111};

  cache_snoop_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SETS(NUM_SETS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .sureq_valid(sureq_valid), .sureq_ready(sureq_ready), .sureq_op(sureq_op), .sureq_addr(sureq_addr),
    .sdrsp_valid(sdrsp_valid), .sdrsp_ready(sdrsp_ready), .sdrsp_rsp(sdrsp_rsp), .sdrsp_data(sdrsp_data),
    .cureq_valid(cureq_valid), .cureq_ready(cureq_ready), .cureq_op(cureq_op), .cureq_addr(cureq_addr),
    .cdrsp_valid(cdrsp_valid), .cdrsp_ready(cdrsp_ready), .cdrsp_rsp(cdrsp_rsp), .cdrsp_data(cdrsp_data),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr), .fill_state(fill_state),
    .fill_data(fill_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_SETS; i++) m_st[i] = 3'b000;
  endtask

  // Outcome of one snoop from the MESI rules; rkind: 0 recall OKAY, 1 recall ERROR, 2 timeout, 3 reset
  task automatic model_snoop(input logic [1:0] op, input logic [ADDR_W-1:0] addr, input int rkind,
                             input logic [DATA_W-1:0] rdata, output bit recall,
                             output logic [1:0] rsp, output logic [DATA_W-1:0] data);
    int i;
    bit hit;
    logic [DATA_W-1:0] line;
    i = int'(addr[3:0]);
    hit = m_st[i][0] && (m_tag[i] == addr[15:4]);
    recall = 1'b0;
    rsp = 2'b00;
    data = '0;
    if (op == 2'b11) begin rsp = 2'b10; return; end
    if (!hit) return;
    line = m_dat[i];
    if (m_st[i] == 3'b111) begin
      recall = 1'b1;
      if (rkind != 0) begin rsp = 2'b10; return; end
      line = rdata;
    end
    case (op)
      2'b00:   begin data = line; m_st[i] = 3'b101; m_dat[i] = line; end
      2'b01:   begin rsp = 2'b01; data = line; m_st[i] = 3'b000; end
      default: begin rsp = 2'b01; m_st[i] = 3'b000; end
    endcase
  endtask

  task automatic resync();
    sureq_valid = 0; fill_valid = 0; cureq_ready = 0; cdrsp_valid = 0; sdrsp_ready = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    in_txn = 0;
    model_reset();
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic do_fill(input logic [ADDR_W-1:0] addr, input logic [2:0] st, input logic [DATA_W-1:0] data);
    fill_valid = 1; fill_addr = addr; fill_state = st; fill_data = data;
    @(posedge clk); #1 fill_valid = 0;
    m_st[int'(addr[3:0])]  = st;
    m_tag[int'(addr[3:0])] = addr[15:4];
    m_dat[int'(addr[3:0])] = data;
  endtask

  task automatic do_snoop(input logic [1:0] op, input logic [ADDR_W-1:0] addr, input int rkind,
                          input logic [DATA_W-1:0] rdata, input int cdly, input int qdly, input int sdly,
                          input bit pin, input logic [1:0] pin_rsp, input logic [DATA_W-1:0] pin_data);
    bit recall;
    logic [1:0] rsp;
    logic [DATA_W-1:0] data;
    int n, rc, lat;
    model_snoop(op, addr, rkind, rdata, recall, rsp, data);
    if (pin) begin
      check("model_rsp", 64'(rsp), 64'(pin_rsp));
      check("model_data", 64'(data), 64'(pin_data));
    end
    exp_rsp = rsp; exp_data = data; exp_recall = recall; exp_cop = op; exp_caddr = addr;
    sureq_valid = 1; sureq_op = op; sureq_addr = addr;
    @(posedge clk); #1;
    sureq_valid = 0; in_txn = 1;
    lat = 3;
    if (recall) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!cureq_valid && n < 8);
      check("cureq_latency", 64'(n), 64'(2));
      if (!cureq_valid) begin resync(); return; end
      repeat (qdly) @(posedge clk);
      #1 cureq_ready = 1;
      @(posedge clk); #1 cureq_ready = 0;
      if (rkind == 3) begin
        repeat (cdly) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        in_txn = 0;
        model_reset();
        repeat (4) begin @(negedge clk); check("no_rsp_after_rst", 64'(sdrsp_valid), 64'(0)); end
        @(posedge clk); #1;
        return;
      end
      if (rkind < 2) begin
        repeat (cdly) @(posedge clk);
        #1;
        cdrsp_valid = 1; cdrsp_rsp = (rkind == 1) ? 2'b01 : 2'b00; cdrsp_data = rdata;
        @(negedge clk); check("cdrsp_ready", 64'(cdrsp_ready), 64'(1));
        @(posedge clk); #1 cdrsp_valid = 0;
        lat = 2;
      end else begin
        lat = TIMEOUT + 2;
      end
    end
    n = 0; rc = 0;
    do begin @(negedge clk); n++; if (cdrsp_ready) rc++; end while (!sdrsp_valid && n < TIMEOUT + 16);
    check("sdrsp_latency", 64'(n), 64'(lat));
    if (recall && rkind == 2) check("wait_cycles", 64'(rc), 64'(TIMEOUT));
    if (!sdrsp_valid) begin resync(); return; end
    if (recall && rkind == 2) begin cdrsp_valid = 1; cdrsp_rsp = 2'b00; cdrsp_data = rdata; end
    repeat (sdly) begin
      @(negedge clk);
      check("sdrsp_held", 64'(sdrsp_valid), 64'(1));
      if (recall && rkind == 2) check("late_cdrsp_ready", 64'(cdrsp_ready), 64'(0));
    end
    #1 sdrsp_ready = 1;
    @(posedge clk); #1;
    sdrsp_ready = 0; cdrsp_valid = 0; in_txn = 0;
  endtask

  // Per-cycle comparison of the DUT against the model's expectations
  always @(negedge clk) begin
    if (rst) begin
      check("rst_ctrl_outputs", 64'({sureq_ready, fill_ready, sdrsp_valid, cureq_valid, cdrsp_ready, busy}), 64'(0));
      check("rst_data_outputs", 64'({sdrsp_rsp, cureq_op, sdrsp_data, cureq_addr}), 64'(0));
    end else begin
      check("sureq_ready", 64'(sureq_ready), 64'(!in_txn));
      check("busy", 64'(busy), 64'(in_txn));
      check("fill_ready", 64'(fill_ready), 64'(!in_txn && !sureq_valid));
      if (sdrsp_valid) begin
        check("sdrsp_in_txn", 64'(in_txn), 64'(1));
        check("sdrsp_rsp", 64'(sdrsp_rsp), 64'(exp_rsp));
        check("sdrsp_data", 64'(sdrsp_data), 64'(exp_data));
      end
      if (cureq_valid) begin
        check("cureq_expected", 64'(exp_recall && in_txn), 64'(1));
        check("cureq_op", 64'(cureq_op), 64'(exp_cop));
        check("cureq_addr", 64'(cureq_addr), 64'(exp_caddr));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] a;
    logic [1:0] op;
    int r, rk;
    for (int i = 0; i < NUM_SETS; i++) begin m_st[i] = 3'b000; m_tag[i] = '0; m_dat[i] = '0; end
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // RD of an EXCLUSIVE line, then again once it has become SHARED
    do_fill(16'h0013, 3'b001, 32'hDEADBEEF);
    do_snoop(2'b00, 16'h0013, 0, 32'h0, 0, 0, 0, 1, 2'b00, 32'hDEADBEEF);
    do_snoop(2'b00, 16'h0013, 0, 32'h0, 0, 0, 0, 1, 2'b00, 32'hDEADBEEF);
    check("model_line_shared", 64'(m_st[3]), 64'(3'b101));

    // RFO of a MIGRATED line recalls from L1, then the line is gone
    do_fill(16'h0013, 3'b111, 32'h0);
    do_snoop(2'b01, 16'h0013, 0, 32'h12345678, 2, 1, 0, 1, 2'b01, 32'h12345678);
    do_snoop(2'b00, 16'h0013, 0, 32'h0, 0, 0, 0, 1, 2'b00, 32'h0);

    // Recall timeout, late cdrsp refused, line still MIGRATED afterwards
    do_fill(16'h0013, 3'b111, 32'h0);
    do_snoop(2'b00, 16'h0013, 2, 32'hAAAA5555, 0, 0, 3, 1, 2'b10, 32'h0);
    do_snoop(2'b00, 16'h0013, 0, 32'h600DCAFE, 0, 0, 0, 1, 2'b00, 32'h600DCAFE);

    // Tag mismatch, illegal op, then the MODIFIED data still readable
    do_fill(16'h0013, 3'b011, 32'hCAFEF00D);
    do_snoop(2'b10, 16'h0113, 0, 32'h0, 0, 0, 0, 1, 2'b00, 32'h0);
    do_snoop(2'b11, 16'h0013, 0, 32'h0, 0, 0, 0, 1, 2'b10, 32'h0);
    do_snoop(2'b00, 16'h0013, 0, 32'h0, 0, 0, 0, 1, 2'b00, 32'hCAFEF00D);

    // Snoop beats a simultaneous fill; response held under 5 cycles of back-pressure
    fill_valid = 1; fill_addr = 16'h0025; fill_state = 3'b001; fill_data = 32'h0BADF00D;
    do_snoop(2'b00, 16'h0013, 0, 32'h0, 0, 0, 5, 1, 2'b00, 32'hCAFEF00D);
    @(posedge clk); #1 fill_valid = 0;
    m_st[5] = 3'b001; m_tag[5] = 12'h002; m_dat[5] = 32'h0BADF00D;
    do_snoop(2'b00, 16'h0025, 0, 32'h0, 0, 0, 0, 1, 2'b00, 32'h0BADF00D);

    // Reset while waiting on the recall
    do_fill(16'h0013, 3'b111, 32'h0);
    do_fill(16'h0024, 3'b001, 32'h00000055);
    do_snoop(2'b01, 16'h0013, 3, 32'h11112222, 5, 0, 0, 0, 2'b00, 32'h0);
    do_snoop(2'b00, 16'h0024, 0, 32'h0, 0, 0, 0, 1, 2'b00, 32'h0);
    do_snoop(2'b00, 16'h0013, 0, 32'h0, 0, 0, 0, 1, 2'b00, 32'h0);

    // Random traffic over a few sets and two tags so hits and conflicts are common
    for (int k = 0; k < 250; k++) begin
      a = {12'($urandom_range(0, 1)), 4'($urandom_range(0, 3))};
      if ($urandom_range(0, 2) == 0) begin
        do_fill(a, fill_sts[$urandom_range(0, 5)], $urandom);
      end else begin
        op = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        r  = $urandom_range(0, 19);
        rk = (r == 0) ? 2 : (r < 4) ? 1 : 0;
        do_snoop(op, a, rk, $urandom, $urandom_range(0, 6), $urandom_range(0, 3),
                 $urandom_range(0, 3), 0, 2'b00, 32'h0);
      end
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
